// File: rtl/fib_index_finder.sv
// Inverse Fibonacci lookup. It steps through the sequence one term per clock
// until the current term reaches or passes the target. It reports that index,
// or the floor index when the target is not a Fibonacci number.
module fib_index_finder #(
  parameter int unsigned BITS = 32
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic [BITS-1:0] INP,
  input  logic            IE,
  output logic [BITS-1:0] OUT,
  output logic            OE,
  output logic            EXACT,
  output logic            BUSY
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [BITS-1:0] IDX_ONE  = BITS'(1);
  localparam logic [BITS+1:0] TERM_ONE = (BITS+2)'(1);

  logic [1:0]      state;
  logic [BITS-1:0] tgt;
  logic [BITS-1:0] idx;
  // Two spare bits: while a <= tgt < 2^BITS, a+b stays below 3*2^BITS, so the sum cannot wrap
  logic [BITS+1:0] a;
  logic [BITS+1:0] b;
  logic [BITS+1:0] tgt_ext;

  assign tgt_ext = {2'b00, tgt};

  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
      tgt   <= '0;
      idx   <= '0;
      a     <= '0;
      b     <= '0;
      OUT   <= '0;
      OE    <= 1'b0;
      EXACT <= 1'b0;
      BUSY  <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (a == tgt_ext) begin
            OUT   <= idx;
            EXACT <= 1'b1;
            OE    <= 1'b1;
            BUSY  <= 1'b0;
            state <= DONE;
          end else if (a > tgt_ext) begin
            // idx is never 0 here because a starts at 0 and 0 <= tgt
            OUT   <= idx - IDX_ONE;
            EXACT <= 1'b0;
            OE    <= 1'b1;
            BUSY  <= 1'b0;
            state <= DONE;
          end else begin
            a   <= b;
            b   <= a + b;
            idx <= idx + IDX_ONE;
          end
        end
        default: begin
          if (IE) begin
            tgt   <= INP;
            a     <= '0;
            b     <= TERM_ONE;
            idx   <= '0;
            OE    <= 1'b0;
            EXACT <= 1'b0;
            BUSY  <= 1'b1;
            state <= RUN;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fib_index_finder.sv
// Directed bench for fib_index_finder. It uses one 32-bit instance and one
// 8-bit instance, and checks results, exactness, latency, restart and reset.
module tb_fib_index_finder;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic [31:0] inp32 = '0;
  logic        ie32 = 1'b0;
  logic [31:0] out32;
  logic        oe32, exact32, busy32;
  logic [7:0]  inp8 = '0;
  logic        ie8 = 1'b0;
  logic [7:0]  out8;
  logic        oe8, exact8, busy8;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 CLK = ~CLK;

  fib_index_finder #(.BITS(32)) dut32 (
    .CLK(CLK), .RST(RST), .INP(inp32), .IE(ie32),
    .OUT(out32), .OE(oe32), .EXACT(exact32), .BUSY(busy32)
  );

  fib_index_finder #(.BITS(8)) dut8 (
    .CLK(CLK), .RST(RST), .INP(inp8), .IE(ie8),
    .OUT(out8), .OE(oe8), .EXACT(exact8), .BUSY(busy8)
  );

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    n_checks++;
    if (observed === expected) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, observed, expected);
  endtask

  function automatic logic [31:0] get_out(input bit w8);
    return w8 ? {24'd0, out8} : out32;
  endfunction
  function automatic logic get_oe(input bit w8);
    return w8 ? oe8 : oe32;
  endfunction
  function automatic logic get_exact(input bit w8);
    return w8 ? exact8 : exact32;
  endfunction
  function automatic logic get_busy(input bit w8);
    return w8 ? busy8 : busy32;
  endfunction

  // Counts edges until OE rises; the bound is 200 edges, and running past it fails the "timeout" check
  task automatic wait_done(input bit w8, input string tag, output int lat);
    lat = 0;
    while (!get_oe(w8) && lat < 200) begin
      @(posedge CLK); #1;
      lat++;
    end
    check({tag, " timeout"}, 64'(get_oe(w8)), 64'd1);
  endtask

  task automatic start(input bit w8, input logic [31:0] t);
    @(negedge CLK);
    if (w8) begin inp8 = t[7:0]; ie8 = 1'b1; end
    else begin inp32 = t; ie32 = 1'b1; end
    @(posedge CLK); #1;
    ie8 = 1'b0; ie32 = 1'b0;
  endtask

  task automatic run(input bit w8, input logic [31:0] t, input logic [31:0] eo,
                     input bit ee, input int el, input string tag);
    int lat;
    start(w8, t);
    check({tag, " busy"}, 64'(get_busy(w8)), 64'd1);
    check({tag, " oe_low"}, 64'(get_oe(w8)), 64'd0);
    wait_done(w8, tag, lat);
    check({tag, " out"}, 64'(get_out(w8)), 64'(eo));
    check({tag, " exact"}, 64'(get_exact(w8)), 64'(ee));
    check({tag, " latency"}, 64'(lat), 64'(el));
    check({tag, " busy_done"}, 64'(get_busy(w8)), 64'd0);
  endtask

  initial begin
    int lat;
    int l2;
    logic [7:0] fib8 [0:13];
    fib8 = '{8'd0, 8'd1, 8'd1, 8'd2, 8'd3, 8'd5, 8'd8, 8'd13, 8'd21,
             8'd34, 8'd55, 8'd89, 8'd144, 8'd233};

    RST = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    check("rst out", 64'(out32), 64'd0);
    check("rst oe", 64'(oe32), 64'd0);
    check("rst exact", 64'(exact32), 64'd0);
    check("rst busy", 64'(busy32), 64'd0);
    check("rst8 busy", 64'(busy8), 64'd0);
    @(negedge CLK); RST = 1'b0;

    run(1'b0, 32'd0,  32'd0, 1'b1, 1, "t0");
    run(1'b0, 32'd1,  32'd1, 1'b1, 2, "t1");
    run(1'b0, 32'd21, 32'd8, 1'b1, 9, "t21");
    run(1'b0, 32'd20, 32'd7, 1'b0, 9, "t20");
    run(1'b0, 32'hFFFF_FFFF, 32'd47, 1'b0, 49, "tmax32");
    run(1'b1, 32'd233, 32'd13, 1'b1, 14, "t233_8");
    run(1'b1, 32'd255, 32'd13, 1'b0, 15, "t255_8");

    // DONE holds its result
    repeat (3) @(posedge CLK);
    #1;
    check("hold oe", 64'(oe8), 64'd1);
    check("hold out", 64'(out8), 64'd13);
    check("hold exact", 64'(exact8), 64'd0);

    // IE pulsed mid-run with a different value must be ignored
    start(1'b0, 32'd89);
    lat = 0;
    repeat (2) begin @(posedge CLK); #1; lat++; end
    @(negedge CLK); inp32 = 32'd5; ie32 = 1'b1;
    @(posedge CLK); #1; lat++; ie32 = 1'b0;
    check("ign busy", 64'(busy32), 64'd1);
    wait_done(1'b0, "ign", l2);
    check("ign out", 64'(out32), 64'd11);
    check("ign exact", 64'(exact32), 64'd1);
    check("ign latency", 64'(lat + l2), 64'd12);
    run(1'b0, 32'd3, 32'd4, 1'b1, 5, "restart3");

    // Reset mid-run, then reset together with IE
    start(1'b0, 32'd144);
    repeat (4) @(posedge CLK);
    @(negedge CLK); RST = 1'b1;
    @(posedge CLK); #1;
    check("midrst out", 64'(out32), 64'd0);
    check("midrst oe", 64'(oe32), 64'd0);
    check("midrst exact", 64'(exact32), 64'd0);
    check("midrst busy", 64'(busy32), 64'd0);
    @(negedge CLK); inp32 = 32'd8; ie32 = 1'b1;
    @(posedge CLK); #1;
    check("rst_ie busy", 64'(busy32), 64'd0);
    check("rst_ie oe", 64'(oe32), 64'd0);
    @(negedge CLK); RST = 1'b0; ie32 = 1'b0;
    @(posedge CLK); #1;
    check("rst_ie idle", 64'(busy32), 64'd0);
    run(1'b0, 32'd8, 32'd6, 1'b1, 7, "t8");

    // Round trip over the 8-bit Fibonacci terms
    for (int k = 0; k < 14; k++) begin
      run(1'b1, 32'(fib8[k]), (k == 2) ? 32'd1 : 32'(k), 1'b1,
          (k == 2) ? 2 : k + 1, $sformatf("rt%0d", k));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
